// File: rtl/intc_pkg.sv
// intc_pkg: shared state encoding, register map and STAT layout for int_req_ctrl
package intc_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;
   localparam logic [1:0] REG_EOI  = 2'd3;
   localparam int STAT_TERR  = 31;
   localparam int STAT_STATE = 16;
   localparam int STAT_ID    = 8;
   function automatic logic [31:0] pack_stat(input logic terr, input logic [1:0] st,
                                             input logic [2:0] id, input logic [7:0] ovr);
      logic [31:0] r;
      r = '0;
      r[STAT_TERR] = terr;
      r[STAT_STATE +: 2] = st;
      r[STAT_ID +: 3] = id;
      r[7:0] = ovr;
      return r;
   endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-first priority encoder producing {valid, index}
module prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [2:0]   index
);
   always_comb begin
      valid = |req;
      index = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) index = 3'(i);
   end
endmodule

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: fixed-priority interrupt requester driving the done/int_ack handshake
module int_req_ctrl
   import intc_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_evt,
   input  logic             int_ack,
   output logic [N_SRC-1:0] done,
   output logic [2:0]       irq_id,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wd,
   output logic [31:0]      rd
);
   state_t           state;
   logic [N_SRC-1:0] pending, mask, eligible, clr, cur_bit;
   logic [7:0]       overrun, timer;
   logic             timeout_err, win_valid, ack, wr_pend, wr_mask, wr_stat, wr_eoi;
   logic [2:0]       win_idx;
   logic             unused_wd;
   assign unused_wd = ^wd[30:8];
   always_comb begin
      wr_pend  = we && addr == REG_PEND;
      wr_mask  = we && addr == REG_MASK;
      wr_stat  = we && addr == REG_STAT;
      wr_eoi   = we && addr == REG_EOI;
      ack      = state == REQ && int_ack;
      cur_bit  = N_SRC'(1) << irq_id;
      eligible = pending & mask;
      clr      = (wr_pend ? wd[N_SRC-1:0] : '0) | (ack ? cur_bit : '0);
      rd       = addr == REG_PEND ? 32'(pending) :
                 addr == REG_MASK ? 32'(mask) :
                 addr == REG_STAT ? pack_stat(timeout_err, state, irq_id, overrun) : '0;
   end
   prio_enc #(.N(N_SRC)) u_prio (
      .req  (eligible),
      .valid(win_valid),
      .index(win_idx)
   );
   // Set terms are applied after clears so a coincident event is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= '0;
         mask        <= '0;
         overrun     <= '0;
         timeout_err <= 1'b0;
         timer       <= '0;
         done        <= '0;
         irq_id      <= '0;
      end else begin
         pending <= (pending & ~clr) | src_evt;
         overrun <= (overrun & ~(wr_stat ? wd[7:0] : 8'h0)) | 8'(src_evt & pending);
         if (wr_mask) mask <= wd[N_SRC-1:0];
         if (wr_stat && wd[STAT_TERR]) timeout_err <= 1'b0;
         case (state)
            IDLE:
               if (win_valid) begin
                  irq_id <= win_idx;
                  done   <= N_SRC'(1) << win_idx;
                  timer  <= '0;
                  state  <= REQ;
               end
            REQ:
               if (int_ack) begin
                  done  <= '0;
                  state <= SERVICE;
               end else if (timer == 8'(TIMEOUT_CYC)) begin
                  timeout_err <= 1'b1;
                  done        <= '0;
                  state       <= IDLE;
               end else if (timer != 8'hFF) begin
                  timer <= timer + 8'd1;
               end
            SERVICE:
               if (wr_eoi) state <= IDLE;
            default: begin
               done  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_int_req_ctrl.sv
// tb_int_req_ctrl: directed scenarios plus random traffic checked against a behavioural model
module tb_int_req_ctrl;
   logic        clk = 0, reset = 0, int_ack = 0, we = 0;
   logic [3:0]  src_evt = 0, done;
   logic [2:0]  irq_id;
   logic [1:0]  addr = 0;
   logic [31:0] wd = 0, rd;
   int n_tests = 0, n_fail = 0;

   int_req_ctrl #(.N_SRC(4), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .reset(reset), .src_evt(src_evt), .int_ack(int_ack), .done(done),
      .irq_id(irq_id), .we(we), .addr(addr), .wd(wd), .rd(rd)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0=idle, 1=requesting, 2=in service; wait counts requesting cycles.
   bit [3:0] m_pend, m_mask;
   bit [7:0] m_ovr;
   bit       m_terr;
   int       m_phase, m_id, m_wait;

   function automatic void model_step();
      bit [3:0] clr, nmask, npend;
      bit [7:0] novr;
      bit       nterr;
      int       pick;
      if (reset) begin
         m_pend = 0; m_mask = 0; m_ovr = 0; m_terr = 0; m_phase = 0; m_id = 0; m_wait = 0;
         return;
      end
      clr = (we && addr == 0) ? wd[3:0] : 4'h0;
      if (m_phase == 1 && int_ack) clr[m_id] = 1;
      npend = (m_pend & ~clr) | src_evt;
      novr  = (m_ovr & ~((we && addr == 2) ? wd[7:0] : 8'h0)) | {4'h0, src_evt & m_pend};
      nterr = m_terr && !(we && addr == 2 && wd[31]);
      nmask = (we && addr == 1) ? wd[3:0] : m_mask;
      if (m_phase == 0) begin
         pick = -1;
         for (int k = 3; k >= 0; k--) if (m_pend[k] && m_mask[k]) pick = k;
         if (pick >= 0) begin m_id = pick; m_phase = 1; m_wait = 0; end
      end else if (m_phase == 1) begin
         if (int_ack) m_phase = 2;
         else if (m_wait == 255) begin nterr = 1; m_phase = 0; end
         else m_wait++;
      end else if (we && addr == 3) m_phase = 0;
      m_pend = npend; m_mask = nmask; m_ovr = novr; m_terr = nterr;
   endfunction

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0: return {28'h0, m_pend};
         2'd1: return {28'h0, m_mask};
         2'd2: return {m_terr, 13'h0, 2'(m_phase), 5'h0, 3'(m_id), m_ovr};
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] e, input logic a, input logic w,
                       input logic [1:0] ad, input logic [31:0] d);
      src_evt = e; int_ack = a; we = w; addr = ad; wd = d;
      @(posedge clk);
      model_step();
      #1;
      chk("done", {28'h0, done}, m_phase == 1 ? 32'(1) << m_id : 32'h0);
      chk("irq_id", {29'h0, irq_id}, 32'(m_id));
      chk("rd", rd, model_rd(addr));
      src_evt = 0; int_ack = 0; we = 0; reset = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 2'd2, 0);
   endtask

   initial begin
      reset = 1; step(0, 0, 0, 0, 0);
      chk("rst_done", {28'h0, done}, 0);
      // 1: single source round trip
      step(0, 0, 1, 1, 32'hF);
      step(4'b0100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t1_done", {28'h0, done}, 32'h4);
      chk("t1_id", {29'h0, irq_id}, 2);
      step(0, 1, 0, 0, 0);
      chk("t1_ack_done", {28'h0, done}, 0);
      chk("t1_pend", rd, 0);
      step(0, 0, 1, 3, 0);
      addr = 2; #1 chk("t1_stat", rd, 32'h0000_0200);
      // 2: two sources, lowest first
      step(4'b1010, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t2_first", {28'h0, done}, 32'h2);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 3, 0);
      step(0, 0, 0, 0, 0);
      chk("t2_second", {28'h0, done}, 32'h8);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 3, 0);
      // 3: masked source waits until enabled
      step(0, 0, 1, 1, 32'h1);
      step(4'b0010, 0, 0, 0, 0);
      idle(2);
      chk("t3_masked", {28'h0, done}, 0);
      step(0, 0, 1, 1, 32'h2);
      step(0, 0, 0, 0, 0);
      chk("t3_enabled", {28'h0, done}, 32'h2);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 3, 0);
      // 4: timeout withdraws the request, then re-arbitrates
      step(0, 0, 1, 1, 32'hF);
      step(4'b0001, 0, 0, 0, 0);
      step(0, 0, 0, 2, 0);
      idle(255);
      chk("t4_held", {28'h0, done}, 32'h1);
      step(0, 0, 0, 2, 0);
      chk("t4_drop", {28'h0, done}, 0);
      chk("t4_terr", {31'h0, rd[31]}, 1);
      step(0, 0, 0, 2, 0);
      chk("t4_rereq", {28'h0, done}, 32'h1);
      step(0, 0, 1, 2, 32'h8000_0000);
      chk("t4_clr", {31'h0, rd[31]}, 0);
      // 5: set beats ack-clear; overrun on a pending source
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 3, 0);
      step(4'b0001, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(4'b0001, 1, 0, 0, 0);
      chk("t5_pend0", {31'h0, rd[0]}, 1);
      step(4'b1000, 0, 0, 2, 0);
      step(4'b1000, 0, 0, 2, 0);
      chk("t5_ovr3", {31'h0, rd[3]}, 1);
      step(0, 0, 1, 2, 32'hFF);
      step(0, 0, 1, 3, 0);
      // 6: reset during a request
      step(0, 0, 0, 0, 0);
      chk("t6_req", {28'h0, done}, 32'h1);
      reset = 1; step(0, 0, 0, 0, 0);
      chk("t6_done", {28'h0, done}, 0);
      chk("t6_pend", rd, 0);
      addr = 1; #1 chk("t6_mask", rd, 0);
      addr = 2; #1 chk("t6_stat", rd, 0);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [1:0]  ra;
         logic [31:0] rw;
         ra = 2'($urandom_range(0, 3));
         rw = $urandom;
         if (ra == 1 && $urandom_range(0, 3) != 0) rw[3:0] = 4'hF;
         reset = $urandom_range(0, 299) == 0;
         step(4'($urandom & $urandom & $urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, ra, rw);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
